// File: rtl/param_stack.sv
// Parametrised LIFO stack with replace-top, peek, occupancy and over/underflow pulses.
// Optional high-water-mark register and port are enabled by defining STACK_HWM_EN.
module param_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
`ifdef STACK_HWM_EN
  output logic [CW-1:0]    hwm,
`endif
  output logic             udf
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_dv;
  logic             r_ovf;
  logic             r_udf;

  logic [CW-1:0]    w_cnt_m1;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_top_idx;
  logic             w_full;
  logic             w_empty;
  logic             w_repl;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [CW-1:0]    w_cnt_nxt;

  assign w_cnt_m1  = r_count - CW'(1);
  assign w_wr_idx  = r_count[AW-1:0];
  assign w_top_idx = w_cnt_m1[AW-1:0];
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);

  // Push&pop on an empty stack degrades to a plain push.
  assign w_repl    = !clr && push && pop && !w_empty;
  assign w_push_ok = !clr && push && !w_repl && !w_full;
  assign w_pop_ok  = !clr && pop && !push && !w_empty;

  always_comb begin
    w_cnt_nxt = r_count;
    if (clr)            w_cnt_nxt = '0;
    else if (w_push_ok) w_cnt_nxt = r_count + CW'(1);
    else if (w_pop_ok)  w_cnt_nxt = w_cnt_m1;
  end

  always_ff @(posedge clk) begin
    if (w_repl)         r_mem[w_top_idx] <= din;
    else if (w_push_ok) r_mem[w_wr_idx]  <= din;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_count <= '0;
      r_dout  <= '0;
      r_dv    <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_count <= w_cnt_nxt;
      r_dv    <= w_repl || w_pop_ok;
      r_ovf   <= !clr && push && !pop && w_full;
      r_udf   <= !clr && pop && !push && w_empty;
      if (w_repl || w_pop_ok) r_dout <= r_mem[w_top_idx];
    end
  end

`ifdef STACK_HWM_EN
  logic [CW-1:0] r_hwm;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                  r_hwm <= '0;
    else if (clr)               r_hwm <= '0;
    else if (w_cnt_nxt > r_hwm) r_hwm <= w_cnt_nxt;
  end
  assign hwm = r_hwm;
`endif

  assign dout       = r_dout;
  assign dout_valid = r_dv;
  assign top        = w_empty ? '0 : r_mem[w_top_idx];
  assign count      = r_count;
  assign full       = w_full;
  assign empty      = w_empty;
  assign ovf        = r_ovf;
  assign udf        = r_udf;
endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack (WIDTH=8, DEPTH=4); hwm checks only when STACK_HWM_EN is defined.
module tb_param_stack;
  logic       clk = 1'b0;
  logic       nrst;
  logic       clr, push, pop;
  logic [7:0] din;
  logic [7:0] dout, top;
  logic       dout_valid, full, empty, ovf, udf;
  logic [2:0] count;
`ifdef STACK_HWM_EN
  logic [2:0] hwm;
`endif

  int n_run  = 0;
  int n_fail = 0;

  param_stack #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .nrst(nrst), .clr(clr), .push(push), .pop(pop), .din(din),
    .dout(dout), .dout_valid(dout_valid), .top(top), .count(count),
    .full(full), .empty(empty), .ovf(ovf),
`ifdef STACK_HWM_EN
    .hwm(hwm),
`endif
    .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one operation across one rising edge; outputs settle by return.
  task automatic cyc(input logic pu, input logic po, input logic cl, input logic [7:0] d);
    push = pu; pop = po; clr = cl; din = d;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; clr = 1'b0; din = 8'h00;
  endtask

  initial begin
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    nrst = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; din = 8'h00;
    #12;
    check("rst_count", count, 0);
    check("rst_dout", dout, 0);
    check("rst_dv", dout_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_udf", udf, 0);
    check("rst_empty", empty, 1);
    check("rst_top", top, 0);
    @(posedge clk); #1 nrst = 1'b1;

    // T1 fill
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, vals[i]);
      check("t1_count", count, i + 1);
      check("t1_top", top, vals[i]);
      check("t1_full", full, (i == 3) ? 1 : 0);
    end

    // T2 overflow
    cyc(1, 0, 0, 8'h55);
    check("t2_ovf", ovf, 1);
    check("t2_count", count, 4);
    check("t2_top", top, 8'h44);
    cyc(0, 0, 0, 8'h00);
    check("t2_ovf_pulse", ovf, 0);

    // T3 drain and underflow
    for (int i = 3; i >= 0; i--) begin
      cyc(0, 1, 0, 8'h00);
      check("t3_dout", dout, vals[i]);
      check("t3_dv", dout_valid, 1);
      check("t3_count", count, i);
    end
    check("t3_empty", empty, 1);
    check("t3_top_empty", top, 0);
    cyc(0, 1, 0, 8'h00);
    check("t3_udf", udf, 1);
    check("t3_dout_hold", dout, 8'h11);
    check("t3_dv_udf", dout_valid, 0);
    cyc(0, 0, 0, 8'h00);
    check("t3_udf_pulse", udf, 0);

    // T4 replace-top
    cyc(1, 0, 0, 8'hA0);
    cyc(1, 0, 0, 8'hA1);
    cyc(1, 1, 0, 8'hB0);
    check("t4_pp_dout", dout, 8'hA1);
    check("t4_pp_dv", dout_valid, 1);
    check("t4_pp_count", count, 2);
    check("t4_pp_top", top, 8'hB0);
    cyc(0, 1, 0, 8'h00);
    check("t4_pop_b0", dout, 8'hB0);
    cyc(0, 1, 0, 8'h00);
    check("t4_pop_a0", dout, 8'hA0);
    cyc(1, 1, 0, 8'hC0);
    check("t4_ppe_count", count, 1);
    check("t4_ppe_dv", dout_valid, 0);
    check("t4_ppe_udf", udf, 0);
    check("t4_ppe_top", top, 8'hC0);
    check("t4_ppe_dout", dout, 8'hA0);

    // Replace-top while full: no overflow
    cyc(1, 0, 0, 8'h01);
    cyc(1, 0, 0, 8'h02);
    cyc(1, 0, 0, 8'h03);
    check("t4f_full", full, 1);
    cyc(1, 1, 0, 8'h99);
    check("t4f_dout", dout, 8'h03);
    check("t4f_count", count, 4);
    check("t4f_ovf", ovf, 0);
    check("t4f_top", top, 8'h99);

    // T5 clear and async reset
    cyc(0, 0, 1, 8'h00);
    check("t5_clr_count", count, 0);
    check("t5_clr_empty", empty, 1);
    check("t5_clr_dout", dout, 8'h03);
    check("t5_clr_dv", dout_valid, 0);
    cyc(1, 0, 0, 8'h21);
    cyc(1, 0, 0, 8'h22);
    cyc(1, 0, 0, 8'h23);
    check("t5_count3", count, 3);
    cyc(1, 0, 1, 8'h24);
    check("t5_clrpush_count", count, 0);
    check("t5_clrpush_dout", dout, 8'h03);
    cyc(1, 0, 0, 8'h77);
    push = 1'b1; din = 8'h78;
    #2 nrst = 1'b0;
    #1;
    check("t5_arst_count", count, 0);
    check("t5_arst_dout", dout, 0);
    check("t5_arst_empty", empty, 1);
    push = 1'b0;
    @(posedge clk); #1 nrst = 1'b1;
    check("t5_post_rst_count", count, 0);

`ifdef STACK_HWM_EN
    // T6 high-water mark
    check("t6_hwm_rst", hwm, 0);
    cyc(1, 0, 0, 8'h01);
    cyc(1, 0, 0, 8'h02);
    cyc(1, 0, 0, 8'h03);
    cyc(0, 1, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    cyc(1, 0, 0, 8'h04);
    check("t6_count", count, 2);
    check("t6_hwm", hwm, 3);
    cyc(0, 0, 1, 8'h00);
    check("t6_hwm_clr", hwm, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
